// File: rtl/ir_remote_rx.sv
// NEC infrared remote receiver.
// Measures mark/space widths of the demodulated IR line in 1 us ticks,
// decodes 32-bit NEC frames and repeat codes, and turns four command codes
// into held button-equivalent levels for the fan controller.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | line idle, waiting for a leader mark to start
// LEAD_MARK  | inside the 9 ms leader mark
// LEAD_SPACE | inside the leader space (4.5 ms frame / 2.25 ms repeat)
// BIT_MARK   | inside the 560 us mark that starts each data bit
// BIT_SPACE  | inside a data bit space; its width encodes the bit
// STOP_MARK  | inside the final mark after bit 31
// REP_MARK   | inside the final mark of a repeat frame
module ir_remote_rx #(
    parameter int         CLK_HZ        = 100_000_000,
    parameter logic [7:0] ADDR          = 8'h00,
    parameter logic [7:0] CMD0          = 8'h45,
    parameter logic [7:0] CMD1          = 8'h46,
    parameter logic [7:0] CMD2          = 8'h47,
    parameter logic [7:0] CMD3          = 8'h44,
    parameter int         HOLD_MS       = 40,
    parameter logic [3:0] REPEAT_MASK   = 4'b0000,
    parameter int         REPEAT_WIN_MS = 110
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       ir_rx,
    output logic [3:0] btn_out,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       rep_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIV     = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_US = HOLD_MS * 1000;
    localparam int HW      = $clog2(HOLD_US + 1);
    localparam int WIN_US  = REPEAT_WIN_MS * 1000;
    localparam int WW      = $clog2(WIN_US + 1);
    localparam logic [13:0] CNT_MAX = 14'd16383;
    localparam logic [13:0] T_OUT   = 14'd12000;

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_MARK
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          sync1, sync2, sync3;
    logic          rise_r, fall_r, edge_r;
    logic [13:0]   width;
    logic [31:0]   sr;
    logic [4:0]    bit_idx;
    logic [HW-1:0] hold_cnt [4];
    logic [WW-1:0] win_cnt;
    logic [3:0]    last_match;

    logic          err, shift_en, shift_bit, eval_frame, eval_rep;
    logic          frame_bad, frame_acc, rep_ok;
    logic [3:0]    match, fire;

    function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    assign tick   = (div_cnt == DW'(DIV - 1));
    assign edge_r = rise_r | fall_r;
    assign busy   = (state != IDLE);

    // 1 us tick prescaler
    always_ff @(posedge clk) begin
        if (reset_p)   div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // two-stage synchronizer plus registered edge detect; idle level is 1
    always_ff @(posedge clk) begin
        if (reset_p) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync3  <= 1'b1;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync1  <= ir_rx;
            sync2  <= sync1;
            sync3  <= sync2;
            rise_r <= sync2 & ~sync3;
            fall_r <= ~sync2 & sync3;
        end
    end

    // width counter; the edge cycle is the first tick of the new interval,
    // so the value seen at the next edge equals the interval in us
    always_ff @(posedge clk) begin
        if (reset_p)                         width <= '0;
        else if (edge_r)                     width <= tick ? 14'd1 : 14'd0;
        else if (tick && width != CNT_MAX)   width <= width + 14'd1;
    end

    // next-state decode, width window checks and timeout
    always_comb begin
        state_nxt  = state;
        err        = 1'b0;
        shift_en   = 1'b0;
        shift_bit  = 1'b0;
        eval_frame = 1'b0;
        eval_rep   = 1'b0;
        case (state)
            IDLE: if (fall_r) state_nxt = LEAD_MARK;
            LEAD_MARK: if (edge_r) begin
                if (in_win(width, 14'd8000, 14'd10000)) state_nxt = LEAD_SPACE;
                else                                    err = 1'b1;
            end
            LEAD_SPACE: if (edge_r) begin
                if (in_win(width, 14'd4000, 14'd5000))      state_nxt = BIT_MARK;
                else if (in_win(width, 14'd2000, 14'd2500)) state_nxt = REP_MARK;
                else                                        err = 1'b1;
            end
            BIT_MARK: if (edge_r) begin
                if (in_win(width, 14'd400, 14'd700)) state_nxt = BIT_SPACE;
                else                                 err = 1'b1;
            end
            BIT_SPACE: if (edge_r) begin
                if (in_win(width, 14'd400, 14'd700)) begin
                    shift_en = 1'b1;
                end else if (in_win(width, 14'd1400, 14'd1900)) begin
                    shift_en  = 1'b1;
                    shift_bit = 1'b1;
                end else begin
                    err = 1'b1;
                end
                if (shift_en) state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
            end
            STOP_MARK: if (edge_r) begin
                if (in_win(width, 14'd400, 14'd700)) eval_frame = 1'b1;
                else                                 err = 1'b1;
                state_nxt = IDLE;
            end
            REP_MARK: if (edge_r) begin
                if (in_win(width, 14'd400, 14'd700)) eval_rep = 1'b1;
                else                                 err = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && !edge_r && width >= T_OUT) err = 1'b1;
        if (err) state_nxt = IDLE;
    end

    // frame/repeat evaluation and button fire requests
    always_comb begin
        match     = 4'b0000;
        match[0]  = (sr[23:16] == CMD0);
        match[1]  = (sr[23:16] == CMD1);
        match[2]  = (sr[23:16] == CMD2);
        match[3]  = (sr[23:16] == CMD3);
        frame_bad = eval_frame && ((sr[7:0] != ~sr[15:8]) || (sr[23:16] != ~sr[31:24]));
        frame_acc = eval_frame && !frame_bad && (sr[7:0] == ADDR);
        rep_ok    = eval_rep && (win_cnt != '0);
        fire      = 4'b0000;
        if (frame_acc)   fire = match;
        else if (rep_ok) fire = last_match & REPEAT_MASK;
    end

    // state register and LSB-first shift register
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state   <= IDLE;
            sr      <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                sr      <= {shift_bit, sr[31:1]};
                bit_idx <= bit_idx + 5'd1;
            end
        end
    end

    // registered status pulses and last decoded command
    always_ff @(posedge clk) begin
        if (reset_p) begin
            cmd_valid  <= 1'b0;
            rep_valid  <= 1'b0;
            frame_err  <= 1'b0;
            cmd_code   <= 8'h00;
            last_match <= 4'b0000;
        end else begin
            cmd_valid <= frame_acc;
            rep_valid <= rep_ok;
            frame_err <= err | frame_bad;
            if (frame_acc) begin
                cmd_code   <= sr[23:16];
                last_match <= match;
            end
        end
    end

    // repeat window down-counter; open while nonzero
    always_ff @(posedge clk) begin
        if (reset_p)                       win_cnt <= '0;
        else if (frame_acc || rep_ok)      win_cnt <= WW'(WIN_US);
        else if (tick && win_cnt != '0)    win_cnt <= win_cnt - 1'b1;
    end

    // per-button hold timers; a fire while already held is ignored
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset_p)                                 hold_cnt[i] <= '0;
            else if (fire[i] && hold_cnt[i] == '0)       hold_cnt[i] <= HW'(HOLD_US);
            else if (tick && hold_cnt[i] != '0)          hold_cnt[i] <= hold_cnt[i] - 1'b1;
        end
    end

    // button level follows its hold timer
    always_comb begin
        btn_out = 4'b0000;
        for (int i = 0; i < 4; i++) btn_out[i] = (hold_cnt[i] != '0);
    end
endmodule
